// File: rtl/lc_dco_cal_pkg.sv
// Shared types and default sizing for the LC DCO frequency-calibration controller.
package lc_dco_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int DEF_SW_WIDTH   = 8;
    localparam int DEF_WIN_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_TOL        = 2;

endpackage

// File: rtl/lc_dco_cal_if.sv
// Control/status bundle between a calibration requester and lc_dco_cal.
interface lc_dco_cal_if
    import lc_dco_cal_pkg::*;
#(
    parameter int SW_WIDTH  = DEF_SW_WIDTH,
    parameter int WIN_WIDTH = DEF_WIN_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

    logic                 start;
    logic [CNT_WIDTH-1:0] target_cnt;
    logic [WIN_WIDTH-1:0] win_len;
    logic [SW_WIDTH-1:0]  sw;
    logic                 busy;
    logic                 done;
    logic                 locked;
    logic [CNT_WIDTH-1:0] meas_cnt;

    // start is a one-cycle request taken only while idle (target_cnt/win_len sampled with it);
    // busy covers the run, done is a one-cycle completion pulse, results hold until next start.
    modport master (
        output start, target_cnt, win_len,
        input  sw, busy, done, locked, meas_cnt
    );

    modport slave (
        input  start, target_cnt, win_len,
        output sw, busy, done, locked, meas_cnt
    );

endinterface

// File: rtl/lc_dco_edge_cnt.sv
// Synchronises the divided DCO clock into clk and counts its rising edges, saturating at all-ones.
module lc_dco_edge_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_async,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_dly;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_edge;

    assign w_edge  = r_sync2 & ~r_dly;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
            if (i_clr) begin
                r_count <= '0;
            end else if (i_en && w_edge && (r_count != '1)) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/lc_dco_cal.sv
// Successive-approximation search of the DCO switch code so the edge count per window meets target.
module lc_dco_cal
    import lc_dco_cal_pkg::*;
#(
    parameter int SW_WIDTH   = DEF_SW_WIDTH,
    parameter int WIN_WIDTH  = DEF_WIN_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int TOL        = DEF_TOL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dco_div_in,
    lc_dco_cal_if.slave  bus,
    output state_e       dbg_state
);

    localparam int IDX_W = (SW_WIDTH > 1) ? $clog2(SW_WIDTH) : 1;
    localparam logic [WIN_WIDTH-1:0] SETTLE_LAST = WIN_WIDTH'(SETTLE_CYC - 1);
    localparam logic [SW_WIDTH-1:0]  SW_MSB      = SW_WIDTH'(1) << (SW_WIDTH - 1);

    state_e               r_state,  w_state_n;
    logic [WIN_WIDTH-1:0] r_cyc,    w_cyc_n;
    logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_n;
    logic                 r_final,  w_final_n;
    logic [SW_WIDTH-1:0]  r_sw,     w_sw_n;
    logic [CNT_WIDTH-1:0] r_target, w_target_n;
    logic [WIN_WIDTH-1:0] r_win,    w_win_n;
    logic [CNT_WIDTH-1:0] r_meas,   w_meas_n;
    logic                 r_locked, w_locked_n;

    logic                 w_cnt_clr;
    logic                 w_cnt_en;
    logic                 w_done;
    logic [CNT_WIDTH-1:0] w_count;
    logic [WIN_WIDTH-1:0] w_win_last;
    logic [IDX_W-1:0]     w_idx_dn;
    logic                 w_fast;
    logic [CNT_WIDTH:0]   w_diff;

    lc_dco_edge_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_edge_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_async (dco_div_in),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

    // A zero-length window is run as a single cycle.
    assign w_win_last = (r_win == '0) ? '0 : (r_win - WIN_WIDTH'(1));
    assign w_idx_dn   = r_bit_idx - IDX_W'(1);
    assign w_fast     = (w_count > r_target);
    assign w_diff     = (w_count >= r_target) ? ({1'b0, w_count} - {1'b0, r_target})
                                              : ({1'b0, r_target} - {1'b0, w_count});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cyc     <= '0;
            r_bit_idx <= '0;
            r_final   <= 1'b0;
            r_sw      <= '0;
            r_target  <= '0;
            r_win     <= '0;
            r_meas    <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cyc     <= w_cyc_n;
            r_bit_idx <= w_bit_idx_n;
            r_final   <= w_final_n;
            r_sw      <= w_sw_n;
            r_target  <= w_target_n;
            r_win     <= w_win_n;
            r_meas    <= w_meas_n;
            r_locked  <= w_locked_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cyc_n     = r_cyc;
        w_bit_idx_n = r_bit_idx;
        w_final_n   = r_final;
        w_sw_n      = r_sw;
        w_target_n  = r_target;
        w_win_n     = r_win;
        w_meas_n    = r_meas;
        w_locked_n  = r_locked;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_target_n  = bus.target_cnt;
                    w_win_n     = bus.win_len;
                    w_sw_n      = SW_MSB;
                    w_bit_idx_n = IDX_W'(SW_WIDTH - 1);
                    w_final_n   = 1'b0;
                    w_locked_n  = 1'b0;
                    w_cyc_n     = '0;
                    w_state_n   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cyc == SETTLE_LAST) begin
                    w_cyc_n   = '0;
                    w_cnt_clr = 1'b1;
                    w_state_n = ST_MEASURE;
                end else begin
                    w_cyc_n = r_cyc + WIN_WIDTH'(1);
                end
            end
            ST_MEASURE: begin
                w_cnt_en = 1'b1;
                if (r_cyc == w_win_last) begin
                    w_cyc_n   = '0;
                    w_state_n = ST_DECIDE;
                end else begin
                    w_cyc_n = r_cyc + WIN_WIDTH'(1);
                end
            end
            ST_DECIDE: begin
                // The counter has absorbed the last window cycle by now, so it is the full count.
                w_meas_n = w_count;
                if (!r_final) begin
                    if (!w_fast) begin
                        w_sw_n[r_bit_idx] = 1'b0;
                    end
                    if (r_bit_idx != '0) begin
                        w_bit_idx_n      = w_idx_dn;
                        w_sw_n[w_idx_dn] = 1'b1;
                    end else begin
                        w_final_n = 1'b1;
                    end
                    w_state_n = ST_SETTLE;
                end else begin
                    w_locked_n = (w_diff <= (CNT_WIDTH + 1)'(TOL));
                    w_state_n  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done    = 1'b1;
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.sw       = r_sw;
    assign bus.busy     = (r_state == ST_SETTLE) || (r_state == ST_MEASURE) || (r_state == ST_DECIDE);
    assign bus.done     = w_done;
    assign bus.locked   = r_locked;
    assign bus.meas_cnt = r_meas;
    assign dbg_state    = r_state;

endmodule

// File: doc/lc_dco_cal.md
Name: lc_dco_cal

Overview:
- Digital frequency-calibration controller for the LC DCO.
- Observes a divided copy of the DCO output, counts its rising edges over a programmable window of reference-clock cycles, and drives the DCO capacitor-switch code `sw`.
- Runs a successive-approximation (MSB-first) search so the measured count approaches a target count.
- Sits between the DCO's `outp`/divider path and its `sw` input; it is the closed-loop driver of that switch bus.

Parameters:
- SW_WIDTH, 8: width of the DCO switch code.
- WIN_WIDTH, 16: width of the measurement-window length.
- CNT_WIDTH, 16: width of the edge counter, target and result.
- SETTLE_CYC, 8: clk cycles to wait after every `sw` change before measuring.
- TOL, 2: lock tolerance, |meas_cnt − target_cnt| ≤ TOL.

Ports:
- clk  in  1  reference clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin calibration.
- target_cnt  in  CNT_WIDTH  desired edge count per window.
- win_len  in  WIN_WIDTH  window length in clk cycles; 0 is treated as 1.
- dco_div_in  in  1  divided DCO output; asynchronous to clk; frequency < clk/4.
- sw  out  SW_WIDTH  DCO switch code.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- locked  out  1  final result within TOL.
- meas_cnt  out  CNT_WIDTH  count from the most recent completed window.

Behaviour:
- Reset: sw=0, busy=0, done=0, locked=0, meas_cnt=0, FSM=IDLE, counters cleared. Applies from any state, mid-measurement included.
- Input conditioning:
  - dco_div_in passes through a 2-flop synchronizer plus one edge-detect flop.
  - An edge is counted when the synchronized signal is 1 and its delayed copy is 0.
  - The edge counter saturates at all-ones; no wrap.
- Code sense is fixed: a larger sw adds capacitance and lowers frequency.
- States:
  - IDLE:
    - Accepts start and latches target_cnt and win_len.
    - Sets sw = 1<<(SW_WIDTH−1) and bit_idx = SW_WIDTH−1.
    - Clears locked and sets busy, then goes to SETTLE.
  - SETTLE:
    - Waits exactly SETTLE_CYC cycles, with edge detection active but not counted.
    - Clears the edge counter on exit, then goes to MEASURE.
  - MEASURE:
    - Counts edges for exactly max(win_len,1) cycles.
    - On exit, registers the count into meas_cnt, then goes to DECIDE.
  - DECIDE (1 cycle), search step (final=0):
    - If meas_cnt > target_cnt (too fast), keep sw[bit_idx]; otherwise clear it. Equality clears.
    - If bit_idx > 0: decrement bit_idx, set sw[bit_idx−1], go to SETTLE.
    - If bit_idx == 0: set final=1 and go to SETTLE for a verification measurement with sw unchanged.
  - DECIDE, final=1:
    - locked = (|meas_cnt − target_cnt| ≤ TOL), computed at CNT_WIDTH+1 bits unsigned-safe.
    - Go to DONE.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- Holding behaviour:
  - sw, locked and meas_cnt hold after DONE until the next start or rst.
  - start while busy is ignored; start in the same cycle as rst is ignored.
- sw changes only on the cycle of a DECIDE→SETTLE transition or on start acceptance.
- Latency from start to done = SW_WIDTH+1 steps × (SETTLE_CYC + max(win_len,1) + 1) + 2 cycles.
- Edges within the 2-cycle synchronizer latency at the window boundary belong to whichever window sees them synchronized. This is accepted measurement error.

Decomposition:
- Package lc_dco_cal_pkg:
  - FSM state enum (IDLE, SETTLE, MEASURE, DECIDE, DONE).
  - Default width constants.
- Sub-module lc_dco_edge_cnt:
  - Synchronizer, edge detect, and saturating counter with clear/enable.
  - Output: count.

Test Plan:
- DCO model producing (200 − sw) edges per window; target_cnt=150, win_len chosen so counts are exact, TOL=2 → search visits 128,64,32,48,56,52,50,49; final sw=49, meas_cnt=151, locked=1, one done pulse at the computed latency.
- Same model, target_cnt=250 (unreachable high) → sw=0, meas_cnt=200, locked=0.
- Target_cnt=0 → every bit kept, sw=255; counter never underflows; locked=0.
- Model saturating the edge counter (win_len=65535 with a fast input) → meas_cnt=16'hFFFF, no wrap.
- rst asserted mid-MEASURE on step 3 → next cycle sw=0, busy=0, locked=0; a fresh start completes normally.
- start pulsed while busy, and win_len=0 → second start ignored, single done; window length is 1 cycle.
